// File: rtl/uart_status_tx.sv
// UART 8N1 status/ack transmitter with a small byte FIFO in front of the serializer.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_status_tx #(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [2:0]                    dbg_state
);

  // Handshake: a byte is taken on every rising edge where tx_valid && tx_ready;
  // tx_data must be stable while tx_valid is high, and tx_ready depends only on
  // registered state, so it never combinationally follows tx_valid.

  localparam int CPB = CLK_HZ / BAUD;
  localparam int TW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  generate
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_status_tx: FIFO_DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [TW-1:0]   r_timer;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic            w_tx_next;
  logic            w_tick;
  logic            w_pop;
  logic            w_push;
  logic            w_nonempty;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

`ifdef UART_TX_PARITY_EN
  logic            r_parity;
`endif

  assign w_tick     = (r_timer == TW'(CPB - 1));
  assign w_nonempty = (r_count != '0);
  assign tx_ready   = (r_count != CW'(FIFO_DEPTH));
  assign w_push     = tx_valid && tx_ready;

  assign tx         = r_tx;
  assign busy       = (r_state != S_IDLE) || w_nonempty;
  assign fifo_count = r_count;
  assign dbg_state  = r_state;

  // FIFO storage needs no reset; only the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // State register plus the bit timer, bit index and shift register it sequences.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
      r_tx    <= w_tx_next;

      if ((r_state == S_IDLE) || w_tick) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TW'(1);
      end

      if (r_state != S_DATA) begin
        r_bit_idx <= '0;
      end else if (w_tick) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end

      if (w_pop) begin
        r_shift  <= r_mem[r_rd_ptr];
`ifdef UART_TX_PARITY_EN
        r_parity <= ^r_mem[r_rd_ptr];
`endif
      end else if ((r_state == S_DATA) && w_tick) begin
        r_shift <= {1'b0, r_shift[7:1]};
      end
    end
  end

  // Next state; a pop happens only on the transitions that load a new frame.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_nonempty) begin
          w_pop        = 1'b1;
          w_next_state = S_START;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          w_next_state = S_PARITY;
`else
          w_next_state = S_STOP;
`endif
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_next_state = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (w_nonempty) begin
            w_pop        = 1'b1;
            w_next_state = S_START;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Line level for the current state; registered so tx is glitch-free.
  always_comb begin
    w_tx_next = 1'b1;
    case (r_state)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = r_shift[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_next = r_parity;
`endif
      default:  w_tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_status_tx.sv
// Bench for uart_status_tx: randomized and directed pushes, with a line-level UART
// receiver model that decodes tx and checks each frame against an expected-byte queue.
module tb_uart_status_tx;

  localparam int CLK_HZ     = 25000000;
  localparam int BAUD       = 115200;
  localparam int FIFO_DEPTH = 4;
  localparam int CPB        = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS      = 11;
`else
  localparam int NBITS      = 10;
`endif
  localparam int FRAME      = NBITS * CPB;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 0;

  logic [7:0] exp_q[$];
  int         starts[$];

  uart_status_tx #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Driver: present a byte and hold it until accepted; tx_valid stays high on return.
  task automatic push_byte(input logic [7:0] b, input bit track, output int waited);
    waited = 0;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && waited < 4 * FRAME) begin
      @(negedge clk);
      waited++;
    end
    chk("push_timeout", int'(waited >= 4 * FRAME), 0);
    if (track) exp_q.push_back(b);
    @(posedge clk);
  endtask

  task automatic end_push();
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 20 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_timeout", int'(guard >= 20 * FRAME), 0);
  endtask

  // Monitor: receiver model sampling tx at bit centres.
  initial begin
    logic [7:0] got;
    logic [7:0] exp_b;
    forever begin
      @(negedge tx);
      if (mon_en) begin
        @(negedge clk);
        starts.push_back(cyc);
        repeat (CPB / 2 - 1) @(negedge clk);
        chk("start_bit", int'(tx), 0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          got[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        chk("parity_bit", int'(tx), int'(^got));
`endif
        repeat (CPB) @(negedge clk);
        chk("stop_bit", int'(tx), 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", int'(got), -1);
        end else begin
          exp_b = exp_q.pop_front();
          chk("frame_data", int'(got), int'(exp_b));
        end
      end
    end
  end

  initial begin
    int waited, lat, low, bad, base;
    logic [7:0] burst [6];
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(tx), 1);
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(fifo_count), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Long idle: outputs must hold their reset values
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || fifo_count !== 0) bad++;
    end
    chk("idle_steady", bad, 0);

    // Single 'T': tx falls two edges after the push edge; 0x54 keeps the line low
    // through start, bit0 and bit1.
    push_byte(8'h54, 1'b1, waited);
    end_push();
    lat = 0;
    while (tx === 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("t2_latency", lat, 2);
    low = 0;
    while (tx === 1'b0 && low < 4 * CPB) begin
      @(negedge clk);
      low++;
    end
    chk("t2_low_run", low, 3 * CPB);
    repeat (FRAME - 2 - 3 * CPB) @(negedge clk);
    chk("t2_busy_in_stop", int'(busy), 1);
    repeat (2) @(negedge clk);
    chk("t2_busy_after_stop", int'(busy), 0);
    chk("t2_tx_idle", int'(tx), 1);
    wait_drain();

    // Back-to-back burst: FIFO fills, sixth byte waits for the first frame to finish
    burst[0] = 8'h54; burst[1] = 8'h4E; burst[2] = 8'h41;
    burst[3] = 8'h42; burst[4] = 8'h43; burst[5] = 8'h44;
    base = starts.size();
    for (int i = 0; i < 5; i++) push_byte(burst[i], 1'b1, waited);
    @(negedge clk);
    chk("t3_full_count", int'(fifo_count), FIFO_DEPTH);
    chk("t3_full_ready", int'(tx_ready), 0);
    push_byte(burst[5], 1'b1, waited);
    chk("t3_sixth_waited", int'(waited >= 9 * CPB), 1);
    end_push();
    wait_drain();
    chk("t3_frames", starts.size() - base, 6);
    for (int i = base + 1; i < starts.size(); i++) begin
      chk("t3_contiguous", starts[i] - starts[i-1], FRAME);
    end

    // Reset in the middle of data bit 3 with one byte still queued
    mon_en = 1'b0;
    push_byte(8'hA5, 1'b0, waited);
    push_byte(8'h0F, 1'b0, waited);
    end_push();
    lat = 0;
    while (tx === 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    repeat (4 * CPB + CPB / 2 - 1) @(negedge clk);
    chk("t4_queued_before", int'(fifo_count), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t4_tx", int'(tx), 1);
    chk("t4_count", int'(fifo_count), 0);
    chk("t4_busy", int'(busy), 0);
    chk("t4_ready", int'(tx_ready), 1);
    bad = 0;
    repeat (3 * CPB) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("t4_stays_idle", bad, 0);
    mon_en = 1'b1;
    push_byte(8'h3C, 1'b1, waited);
    end_push();
    wait_drain();

    // Random bytes with random gaps (some long enough to return to idle)
    for (int i = 0; i < 12; i++) begin
      push_byte(8'($urandom_range(0, 255)), 1'b1, waited);
      if ($urandom_range(0, 2) == 0) begin
        end_push();
        repeat ($urandom_range(1, 3000)) @(negedge clk);
      end
    end
    end_push();
    wait_drain();
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_tx", int'(tx), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
